// File: rtl/dual_port_dmem.sv
// Dual-port 512x16 data memory: write-first 1-cycle reads, p1-over-p0 write priority,
// post-reset zero-fill sequencer. Define DMEM_MMIO_EN to map the top address to an LED register.
module dual_port_dmem #(
  parameter int          ADDR_W         = 9,
  parameter int          DATA_W         = 16,
  parameter int unsigned DEPTH          = 512,
  parameter int          CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] p0_DM_maddr,
  input  logic [DATA_W-1:0] p0_DM_wdata,
  input  logic              p0_DM_write_mem,
  output logic [DATA_W-1:0] p0_DM_rdata,
  input  logic [ADDR_W-1:0] p1_DM_maddr,
  input  logic [DATA_W-1:0] p1_DM_wdata,
  input  logic              p1_DM_write_mem,
  output logic [DATA_W-1:0] p1_DM_rdata,
  output logic              mem_ready
`ifdef DMEM_MMIO_EN
  ,
  output logic [DATA_W-1:0] led_out
`endif
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
`ifdef DMEM_MMIO_EN
  localparam logic [ADDR_W-1:0] MMIO_ADDR = '1;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd0;
  logic [DATA_W-1:0] r_rd1;
  logic              w_run;
  logic              w_clr;
  logic              w_wr0_any;
  logic              w_wr1_any;
  logic              w_we0;
  logic              w_we1;
  logic [DATA_W-1:0] w_rd0;
  logic [DATA_W-1:0] w_rd1;
`ifdef DMEM_MMIO_EN
  logic [DATA_W-1:0] r_led;
  logic              w_led_we0;
  logic              w_led_we1;
`endif

  function automatic logic f_in_array(input logic [ADDR_W-1:0] a);
`ifdef DMEM_MMIO_EN
    return (32'(a) < DEPTH) && (a != MMIO_ADDR);
`else
    return 32'(a) < DEPTH;
`endif
  endfunction

  function automatic logic f_decoded(input logic [ADDR_W-1:0] a);
`ifdef DMEM_MMIO_EN
    return f_in_array(a) || (a == MMIO_ADDR);
`else
    return f_in_array(a);
`endif
  endfunction

  // Write-first read: same-cycle stores win over storage, p1 ahead of p0.
  function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] a);
    if (!f_decoded(a))                          return '0;
    if (w_wr1_any && (p1_DM_maddr == a))        return p1_DM_wdata;
    if (w_wr0_any && (p0_DM_maddr == a))        return p0_DM_wdata;
`ifdef DMEM_MMIO_EN
    if (a == MMIO_ADDR)                         return r_led;
`endif
    return r_mem[a];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= INIT;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == INIT) begin
      if ((CLEAR_ON_RESET == 0) || (r_clr_cnt == LAST_ADDR)) w_state_nxt = RUN;
    end
  end

  always_comb begin
    w_run     = (r_state == RUN);
    w_clr     = (r_state == INIT) && (CLEAR_ON_RESET != 0);
    mem_ready = w_run;
  end

  always_comb begin
    w_wr0_any = w_run && p0_DM_write_mem;
    w_wr1_any = w_run && p1_DM_write_mem;
    w_we1     = w_wr1_any && f_in_array(p1_DM_maddr);
    w_we0     = w_wr0_any && f_in_array(p0_DM_maddr) &&
                !(w_wr1_any && (p1_DM_maddr == p0_DM_maddr));
    w_rd0     = f_read(p0_DM_maddr);
    w_rd1     = f_read(p1_DM_maddr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_clr_cnt <= '0;
    else if (w_clr) r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_mem[r_clr_cnt] <= '0;
    end else begin
      if (w_we0) r_mem[p0_DM_maddr] <= p0_DM_wdata;
      if (w_we1) r_mem[p1_DM_maddr] <= p1_DM_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd0 <= '0;
      r_rd1 <= '0;
    end else if (w_run) begin
      r_rd0 <= w_rd0;
      r_rd1 <= w_rd1;
    end else begin
      r_rd0 <= '0;
      r_rd1 <= '0;
    end
  end

  assign p0_DM_rdata = r_rd0;
  assign p1_DM_rdata = r_rd1;

`ifdef DMEM_MMIO_EN
  always_comb begin
    w_led_we1 = w_wr1_any && (p1_DM_maddr == MMIO_ADDR);
    w_led_we0 = w_wr0_any && (p0_DM_maddr == MMIO_ADDR) && !w_led_we1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_led <= '0;
    else if (w_led_we1) r_led <= p1_DM_wdata;
    else if (w_led_we0) r_led <= p0_DM_wdata;
  end

  assign led_out = r_led;
`endif

endmodule
